led_rng_display: RTL and testbench



---
 rtl/led_rng_pkg.sv | 19 +
 rtl/led_rng_ticker.sv | 28 ++
 rtl/led_rng_display.sv | 128 ++++++++++++
 tb/tb_led_rng_display.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_rng_pkg.sv
// Shared types and constants for the RNG-driven LED display.
package led_rng_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_PWM    = 2'd1,
    MODE_SCROLL = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_e;

  localparam int unsigned MISSED_W   = 8;
  localparam int unsigned MISSED_MAX = 255;

endpackage

// File: rtl/led_rng_ticker.sv
// Free-running period counter; tick_c is high during the last count of each period.
module led_rng_ticker #(
  parameter int unsigned PERIOD_CYCLES = 200_000_000
) (
  input  logic clock,
  input  logic reset_n,
  output logic tick_c
);

  localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign tick_c = (count_q == LAST);

  // Explicit wrap so non-power-of-two periods work.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    if (tick_c) count_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/led_rng_display.sv
// LED front end for the RNG: periodic sample requests over valid/ready and
// a registered display in static, PWM, scroll or off mode.
module led_rng_display
  import led_rng_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 4,
  parameter int unsigned PERIOD_CYCLES = 200_000_000,
  parameter int unsigned PWM_BITS      = 8,
  parameter int unsigned RNG_WIDTH     = 512
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [RNG_WIDTH-1:0] rng_data,
  input  logic                 rng_valid,
  output logic                 rng_ready,
  input  logic [1:0]           mode,
  input  logic                 hold,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 sample_strobe,
  output logic [MISSED_W-1:0]  missed_ticks
);

  localparam int unsigned SAMPLE_W = NUM_LEDS * PWM_BITS;

  if (RNG_WIDTH < SAMPLE_W) begin : g_chk_width
    $error("led_rng_display: RNG_WIDTH must be >= NUM_LEDS*PWM_BITS");
  end
  if (NUM_LEDS < 2) begin : g_chk_leds
    $error("led_rng_display: NUM_LEDS must be >= 2");
  end
  if (PERIOD_CYCLES < 2) begin : g_chk_period
    $error("led_rng_display: PERIOD_CYCLES must be >= 2");
  end

  // Sample bits beyond the PWM fields never reach the display.
  if (RNG_WIDTH > SAMPLE_W) begin : g_unused_hi
    logic unused_rng_hi;
    assign unused_rng_hi = ^rng_data[RNG_WIDTH-1:SAMPLE_W];
  end

  logic tick_c;

  led_rng_ticker #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_ticker (
    .clock  (clock),
    .reset_n(reset_n),
    .tick_c (tick_c)
  );

  state_e                state_q, state_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [NUM_LEDS-1:0]   scroll_q, scroll_d;
  logic [PWM_BITS-1:0]   pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]   leds_q, leds_d;
  logic                  strobe_q, strobe_d;
  logic [MISSED_W-1:0]   missed_q, missed_d;
  logic [NUM_LEDS-1:0]   pwm_on_c;

  assign rng_ready     = (state_q == ST_REQ);
  assign leds          = leds_q;
  assign sample_strobe = strobe_q;
  assign missed_ticks  = missed_q;

  // Request/capture FSM; ticks during an outstanding request are counted, not queued.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    scroll_d = scroll_q;
    strobe_d = 1'b0;
    missed_d = missed_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_c && !hold) state_d = ST_IDLE == ST_IDLE ? ST_REQ : ST_IDLE;
      end
      ST_REQ: begin
        if (tick_c && (missed_q != MISSED_W'(MISSED_MAX))) begin
          missed_d = missed_q + MISSED_W'(1);
        end
        if (rng_valid) begin
          state_d  = ST_IDLE;
          sample_d = rng_data[SAMPLE_W-1:0];
          scroll_d = {scroll_q[NUM_LEDS-2:0], rng_data[0]};
          strobe_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_pwm
    assign pwm_on_c[g] = (sample_q[g*PWM_BITS +: PWM_BITS] > pwm_q);
  end

  // Display mux, registered so mode changes show one cycle later.
  always_comb begin
    pwm_d  = pwm_q + PWM_BITS'(1);
    leds_d = '0;
    case (mode_e'(mode))
      MODE_STATIC: leds_d = sample_q[NUM_LEDS-1:0];
      MODE_PWM:    leds_d = pwm_on_c;
      MODE_SCROLL: leds_d = scroll_q;
      MODE_OFF:    leds_d = '0;
      default:     leds_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      sample_q <= '0;
      scroll_q <= '0;
      pwm_q    <= '0;
      leds_q   <= '0;
      strobe_q <= 1'b0;
      missed_q <= '0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      scroll_q <= scroll_d;
      pwm_q    <= pwm_d;
      leds_q   <= leds_d;
      strobe_q <= strobe_d;
      missed_q <= missed_d;
    end
  end

endmodule

// File: tb/tb_led_rng_display.sv
// Self-checking bench for led_rng_display: directed scenarios plus random
// traffic, compared each cycle against a cycle-count based reference model.
module tb_led_rng_display;

  localparam int NL  = 4;
  localparam int PER = 16;
  localparam int PB  = 8;
  localparam int RW  = 32;

  logic          clock     = 1'b0;
  logic          reset_n   = 1'b0;
  logic [RW-1:0] rng_data  = '0;
  logic          rng_valid = 1'b0;
  logic          rng_ready;
  logic [1:0]    mode      = 2'd0;
  logic          hold      = 1'b0;
  logic [NL-1:0] leds;
  logic          sample_strobe;
  logic [7:0]    missed_ticks;

  led_rng_display #(
    .NUM_LEDS     (NL),
    .PERIOD_CYCLES(PER),
    .PWM_BITS     (PB),
    .RNG_WIDTH    (RW)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .rng_data     (rng_data),
    .rng_valid    (rng_valid),
    .rng_ready    (rng_ready),
    .mode         (mode),
    .hold         (hold),
    .leds         (leds),
    .sample_strobe(sample_strobe),
    .missed_ticks (missed_ticks)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state: elapsed cycles, outstanding request, captured data.
  int          m_cyc    = 0;
  bit          m_pend   = 1'b0;
  logic [31:0] m_sample = '0;
  int          m_scroll = 0;
  int          m_pwm    = 0;
  int          m_leds   = 0;
  bit          m_strobe = 1'b0;
  int          m_missed = 0;

  function automatic int exp_leds(input logic [1:0] md, input logic [31:0] smp,
                                  input int scr, input int pw);
    int r;
    r = 0;
    case (md)
      2'd0: r = int'(smp % 32'd16);
      2'd1: for (int i = 0; i < NL; i++) if (int'((smp >> (PB * i)) % 32'd256) > pw) r += (1 << i);
      2'd2: r = scr;
      default: r = 0;
    endcase
    return r;
  endfunction

  function automatic bit is_tick(input int c);
    return (c % PER) == (PER - 1);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_cyc    <= 0;
      m_pend   <= 1'b0;
      m_sample <= '0;
      m_scroll <= 0;
      m_pwm    <= 0;
      m_leds   <= 0;
      m_strobe <= 1'b0;
      m_missed <= 0;
    end else begin
      m_cyc    <= m_cyc + 1;
      m_pwm    <= (m_pwm + 1) % 256;
      m_leds   <= exp_leds(mode, m_sample, m_scroll, m_pwm);
      m_strobe <= m_pend && rng_valid;
      if (m_pend && rng_valid) begin
        m_sample <= rng_data;
        m_scroll <= (m_scroll * 2 + int'(rng_data[0])) % 16;
      end
      if (m_pend && is_tick(m_cyc) && m_missed < 255) m_missed <= m_missed + 1;
      m_pend <= m_pend ? !rng_valid : (is_tick(m_cyc) && !hold);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
    cyc++;
    check("model_ready",  32'(rng_ready),     32'(m_pend));
    check("model_strobe", 32'(sample_strobe), 32'(m_strobe));
    check("model_leds",   32'(leds),          32'(m_leds));
    check("model_missed", 32'(missed_ticks),  32'(m_missed));
  endtask

  task automatic wait_ready(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      ok = rng_ready;
    end
  endtask

  task automatic wait_strobe(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      step();
      ok = sample_strobe;
    end
  endtask

  initial begin
    bit ok;
    int n_hi;
    int on_cnt [NL];
    int pwm_exp [NL] = '{0, 64, 128, 255};
    int scr_bit [4]  = '{1, 0, 1, 1};
    int scr_exp [4]  = '{4'b0001, 4'b0010, 4'b0101, 4'b1011};

    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc     = 0;
    check("rst_ready",  32'(rng_ready),     32'd0);
    check("rst_leds",   32'(leds),          32'd0);
    check("rst_strobe", 32'(sample_strobe), 32'd0);
    check("rst_missed", 32'(missed_ticks),  32'd0);

    // First request with valid tied high, static display of 4'hA.
    mode      = 2'd0;
    rng_valid = 1'b1;
    rng_data  = ($urandom() & 32'hFFFF_FFF0) | 32'hA;
    while (cyc < 15) step();
    check("t1_ready_c15", 32'(rng_ready), 32'd0);
    step();
    check("t1_ready_c16", 32'(rng_ready), 32'd1);
    step();
    check("t1_ready_c17",  32'(rng_ready),     32'd0);
    check("t1_strobe_c17", 32'(sample_strobe), 32'd1);
    step();
    check("t1_leds_c18", 32'(leds), 32'hA);

    // Valid withheld for 40 cycles: request stays up, two ticks missed.
    rng_valid = 1'b0;
    wait_ready(40, ok);
    check("t2_req_seen", 32'(ok), 32'd1);
    check("t2_req_cyc",  32'(cyc), 32'd32);
    n_hi = 0;
    repeat (40) begin
      step();
      if (rng_ready) n_hi++;
    end
    check("t2_ready_held", 32'(n_hi), 32'd40);
    check("t2_missed",     32'(missed_ticks), 32'd2);
    rng_data  = $urandom();
    rng_valid = 1'b1;
    step();
    check("t2_strobe",  32'(sample_strobe), 32'd1);
    check("t2_ready_0", 32'(rng_ready),     32'd0);
    rng_valid = 1'b0;
    step();
    check("t2_single", 32'(sample_strobe), 32'd0);

    // PWM duties 0x00/0x40/0x80/0xFF measured over 256 cycles.
    mode      = 2'd1;
    rng_data  = 32'hFF80_4000;
    rng_valid = 1'b1;
    wait_strobe(40, ok);
    check("t3_capture", 32'(ok), 32'd1);
    rng_valid = 1'b0;
    step();
    for (int i = 0; i < NL; i++) on_cnt[i] = 0;
    repeat (256) begin
      step();
      for (int i = 0; i < NL; i++) if (leds[i]) on_cnt[i]++;
    end
    for (int i = 0; i < NL; i++) check($sformatf("t3_pwm_on%0d", i), 32'(on_cnt[i]), 32'(pwm_exp[i]));
    check("t3_req_pending", 32'(rng_ready), 32'd1);

    // Reset during an outstanding request.
    reset_n = 1'b0;
    #1;
    check("t6_ready",  32'(rng_ready),     32'd0);
    check("t6_leds",   32'(leds),          32'd0);
    check("t6_strobe", 32'(sample_strobe), 32'd0);
    check("t6_missed", 32'(missed_ticks),  32'd0);
    mode = 2'd2;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc     = 0;
    while (cyc < 15) step();
    check("t6_ready_c15", 32'(rng_ready), 32'd0);
    step();
    check("t6_ready_c16", 32'(rng_ready), 32'd1);

    // Scroll captures with bit0 = 1,0,1,1.
    for (int k = 0; k < 4; k++) begin
      rng_data  = ($urandom() & 32'hFFFF_FFF0) | 32'(scr_bit[k]);
      rng_valid = 1'b1;
      wait_strobe(40, ok);
      check($sformatf("t4_capture%0d", k), 32'(ok), 32'd1);
      rng_valid = 1'b0;
      step();
      check($sformatf("t4_scroll%0d", k), 32'(leds), 32'(scr_exp[k]));
    end

    // Hold for three periods: no requests, display frozen on last sample.
    mode = 2'd0;
    hold = 1'b1;
    n_hi = 0;
    repeat (3 * PER) begin
      step();
      if (rng_ready) n_hi++;
    end
    check("t5_no_req", 32'(n_hi),         32'd0);
    check("t5_leds",   32'(leds),         32'b0001);
    check("t5_missed", 32'(missed_ticks), 32'd0);
    hold = 1'b0;
    wait_ready(PER + 1, ok);
    check("t5_release_req", 32'(ok),       32'd1);
    check("t5_req_phase",   32'(cyc % PER), 32'd0);

    // Random traffic against the model.
    repeat (400) begin
      mode      = 2'($urandom_range(0, 3));
      hold      = ($urandom_range(0, 3) == 0);
      rng_valid = 1'($urandom_range(0, 1));
      rng_data  = $urandom();
      step();
    end

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
